// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } mul_state_e;

  // Step counter width; at least one bit so WIDTH=1 still elaborates.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul_add_step.sv
// One conditional add of the shift-add multiplier: ripple add of mcand onto hi when lsb is set,
// otherwise a pass-through of hi with zero carry.
module mul_add_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] mcand,
  input  logic             lsb,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  always_comb begin
    logic             c;
    logic [WIDTH-1:0] addend;
    c      = 1'b0;
    sum    = '0;
    addend = lsb ? mcand : '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = hi[i] ^ addend[i] ^ c;
      c      = (hi[i] & addend[i]) | (hi[i] & c) | (addend[i] & c);
    end
    carry = c;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one conditional add per clock, valid/ready on both
// sides. Define MUL_ZERO_SKIP_EN to bypass the add loop when either operand is zero.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  mul_state_e       state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH-1:0]   step_sum;
  logic               step_carry;
  logic [2*WIDTH-1:0] p_next;

  mul_add_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .hi   (p_q[2*WIDTH-1:WIDTH]),
    .mcand(mcand_q),
    .lsb  (p_q[0]),
    .sum  (step_sum),
    .carry(step_carry)
  );

  // Carry-out becomes the new MSB, so the shifted accumulator never overflows.
  assign p_next = {step_carry, step_sum, p_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mcand_q  <= a;
            p_q      <= {{WIDTH{1'b0}}, b};
            cnt_q    <= '0;
            in_ready <= 1'b0;
`ifdef MUL_ZERO_SKIP_EN
            if (a == '0 || b == '0) begin
              state_q   <= StDone;
              p_q       <= '0;
              product   <= '0;
              out_valid <= 1'b1;
            end else begin
              state_q <= StCalc;
              busy    <= 1'b1;
            end
`else
            state_q <= StCalc;
            busy    <= 1'b1;
`endif
          end
        end
        StCalc: begin
          p_q <= p_next;
          if (cnt_q == LastCnt) begin
            state_q   <= StDone;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            product   <= p_next;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: a transaction-level model checked every cycle, plus
// literal expectations per scenario. Honours MUL_ZERO_SKIP_EN like the design.
module tb_shift_add_multiplier;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] product;
  logic          busy;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  shift_add_multiplier #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: idle / computing for N cycles / holding a result.
  bit          m_idle = 1'b1;
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [63:0] m_pending = '0;
  logic [63:0] m_prod = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idle = 1'b1;
      m_left = 0;
      m_done = 1'b0;
      m_prod = '0;
    end else if (m_idle && in_valid) begin
      m_idle    = 1'b0;
      m_pending = 64'(a) * 64'(b);
`ifdef MUL_ZERO_SKIP_EN
      if (a == 0 || b == 0) begin
        m_done = 1'b1;
        m_prod = '0;
      end else begin
        m_left = W;
      end
`else
      m_left = W;
`endif
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_prod = m_pending;
      end
    end else if (m_done && out_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_in_ready", 64'(in_ready), 64'(m_idle));
      chk("cyc_busy", 64'(busy), 64'(m_left > 0));
      chk("cyc_out_valid", 64'(out_valid), 64'(m_done));
      chk("cyc_product", product, m_prod);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  // Issue one operation from idle; out_ready held 0 for 'hold' cycles of DONE (0 = ready throughout).
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input int hold, input logic [63:0] exp_p, input int exp_lat);
    int n;
    chk({name, "_pre_ready"}, 64'(in_ready), 64'd1);
    a         = ta;
    b         = tb_v;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~ta;
    b        = ~tb_v;
    if (exp_lat > 0) chk({name, "_ready_low"}, 64'(in_ready), 64'd0);
    wait_valid(n);
    chk({name, "_latency"}, 64'(n), 64'(exp_lat));
    chk({name, "_product"}, product, exp_p);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_held_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_held_product"}, product, exp_p);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_drop_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n;
    int extra;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_product", product, 64'd0);
    rst_n   = 1'b1;
    started = 1'b1;
    @(posedge clk);
    #1;

    run_op("small", 32'd3, 32'd5, 0, 64'd15, W);
    run_op("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, W);
    run_op("stall", 32'h1234_5678, 32'h9ABC_DEF0, 10, 64'h0B00_EA4E_242D_2080, W);

    // Second request mid-computation must be ignored.
    a         = 32'd11;
    b         = 32'd13;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 32'd7;
    b        = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(n);
    chk("ignore_product", product, 64'd143);
    @(posedge clk);
    #1;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) extra++;
    end
    chk("ignore_no_extra_valid", 64'(extra), 64'd0);
    out_ready = 1'b0;

    // Reset during the computation aborts it.
    a        = 32'h0000_BEEF;
    b        = 32'h0000_CAFE;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_product", product, 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    run_op("after_abort", 32'd2, 32'd9, 0, 64'd18, W);

`ifdef MUL_ZERO_SKIP_EN
    run_op("zero_a", 32'd0, 32'd123, 0, 64'd0, 0);
`else
    run_op("zero_a", 32'd0, 32'd123, 0, 64'd0, W);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
